// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants (S-box, round constants) and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES256_NK = 8;
    localparam int AES256_NR = 14;

    typedef enum logic [0:0] {
        KS_IDLE   = 1'b0,
        KS_EXPAND = 1'b1
    } ks_state_e;

    // Entry 0 is unused; rcon[j] applies to word 8*j.
    localparam logic [7:0] RCON [8] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational 8-bit AES S-box lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = SBOX[i_byte];

endmodule
`default_nettype wire

// File: rtl/aes256_key_expand_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes256_key_expand_seq
// Description : Iterative AES-256 key schedule, one word per clock, with a
//               random-access round-key read port.
// Revision    : 1.0 - initial release
// ============================================================================
module aes256_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NK = AES256_NK,
    parameter int NR = AES256_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    localparam int         NW       = 4 * (NR + 1);
    localparam logic [5:0] LAST_IDX = 6'(NW - 1);

    ks_state_e   state_q, state_d;
    logic [5:0]  i_q, i_d;
    logic [31:0] w_q [NW];
    logic [31:0] w_d [NW];
    logic        done_q, done_d;
    logic        rk_valid_q, rk_valid_d;

    logic [31:0] w_prev, w_back, sub_in, sub_out, t_word;
    logic [7:0]  rcon_byte;
    logic [5:0]  rk_base;

    assign w_prev    = w_q[i_q - 6'd1];
    assign w_back    = w_q[i_q - 6'd8];
    assign sub_in    = (i_q[2:0] == 3'd0) ? rot_word(w_prev) : w_prev;
    assign rcon_byte = RCON[i_q[5:3]];

    generate
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (sub_in[8*b +: 8]),
                .o_byte (sub_out[8*b +: 8])
            );
        end
    endgenerate

    always_comb begin
        t_word = w_prev;
        case (i_q[2:0])
            3'd0:    t_word = sub_out ^ {rcon_byte, 24'h0};
            3'd4:    t_word = sub_out;
            default: t_word = w_prev;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        w_d        = w_q;
        done_d     = 1'b0;
        rk_valid_d = rk_valid_q;
        case (state_q)
            KS_IDLE: begin
                // A start coinciding with the done pulse is still treated as busy.
                if (start && !done_q) begin
                    for (int k = 0; k < NK; k++) begin
                        w_d[k] = key_in[255 - 32*k -: 32];
                    end
                    i_d        = 6'(NK);
                    rk_valid_d = 1'b0;
                    state_d    = KS_EXPAND;
                end
            end
            KS_EXPAND: begin
                w_d[i_q] = w_back ^ t_word;
                i_d      = i_q + 6'd1;
                if (i_q == LAST_IDX) begin
                    done_d     = 1'b1;
                    rk_valid_d = 1'b1;
                    state_d    = KS_IDLE;
                end
            end
            default: state_d = KS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= KS_IDLE;
            i_q        <= 6'd0;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            done_q     <= done_d;
            rk_valid_q <= rk_valid_d;
            w_q        <= w_d;
        end
    end

    assign busy     = (state_q == KS_EXPAND);
    assign done     = done_q;
    assign rk_valid = rk_valid_q;
    assign rk_base  = {rk_addr, 2'b00};

    always_comb begin
        rk_data = 128'h0;
        if (rk_addr <= 4'(NR)) begin
            rk_data = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes256_key_expand_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes256_key_expand_seq
// Description : Scoreboard bench for the iterative AES-256 key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes256_key_expand_seq;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] data;
        string        tag;
    } exp_t;

    exp_t         sb [$];
    logic [127:0] ref_rk [15];
    logic [127:0] dut_rk [15];

    localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    always #5 clk = ~clk;

    aes256_key_expand_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .done     (done),
        .rk_valid (rk_valid),
        .rk_addr  (rk_addr),
        .rk_data  (rk_data)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // Byte-oriented reference schedule; rcon is generated by doubling.
    function automatic void ref_expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = {SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]], SBOX[t[31:24]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic void push_ref(input string tag);
        for (int r = 0; r < 15; r++) sb.push_back('{4'(r), ref_rk[r], $sformatf("%s_rk%0d", tag, r)});
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0]   s   [16];
        logic [7:0]   tmp [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk;
        logic [127:0] ct;
        rk = dut_rk[0];
        for (int k = 0; k < 16; k++) s[k] = pt[127 - 8*k -: 8] ^ rk[127 - 8*k -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int k = 0; k < 16; k++) tmp[k] = SBOX[s[k]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[row + 4*c] = tmp[row + 4*((c + row) % 4)];
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            rk = dut_rk[r];
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[127 - 8*k -: 8];
        end
        for (int k = 0; k < 16; k++) ct[127 - 8*k -: 8] = s[k];
        return ct;
    endfunction

    // key_in is scrambled right after acceptance: only the accept cycle may matter.
    task automatic start_key(input logic [255:0] key);
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        key_in = ~key;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 80 && cyc < 0; c++) begin
            tick();
            if (done === 1'b1) cyc = c;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; start = 1'b0; key_in = '0; rk_addr = 4'd0;
        tick(); tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (rk_valid !== 1'b0) begin n_err++; $display("FAIL reset_rk_valid: got %b want 0", rk_valid); end
        rst = 1'b0;
        sb.push_back('{4'd0, 128'h0, "reset_rk0"});
        sb.push_back('{4'd14, 128'h0, "reset_rk14"});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rk_addr = e.addr; @(negedge clk);
            n_vec++;
            if (rk_data !== e.data) begin n_err++; $display("FAIL %s: got %h want %h", e.tag, rk_data, e.data); end
        end
    endtask

    task automatic test_known_key();
        exp_t e;
        int   cyc;
        start_key(KEY1);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL known_busy: got %b want 1", busy); end
        wait_done(cyc);
        n_vec++; if (cyc != 52) begin n_err++; $display("FAIL known_latency: got %0d want 52", cyc); end
        n_vec++; if (rk_valid !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL known_flags: rk_valid=%b busy=%b want 1 0", rk_valid, busy); end
        tick();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL known_done_pulse: got %b want 0", done); end
        sb.push_back('{4'd0,  128'h000102030405060708090a0b0c0d0e0f, "known_rk0"});
        sb.push_back('{4'd1,  128'h101112131415161718191a1b1c1d1e1f, "known_rk1"});
        sb.push_back('{4'd2,  128'ha573c29fa176c498a97fce93a572c09c, "known_rk2"});
        sb.push_back('{4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "known_rk14"});
        ref_expand(KEY1);
        push_ref("known");
        while (sb.size() > 0) begin
            e = sb.pop_front(); rk_addr = e.addr; @(negedge clk);
            n_vec++;
            if (rk_data !== e.data) begin n_err++; $display("FAIL %s: got %h want %h", e.tag, rk_data, e.data); end
        end
    endtask

    task automatic test_cipher();
        logic [127:0] ct;
        for (int r = 0; r < 15; r++) begin
            rk_addr = 4'(r);
            @(negedge clk);
            dut_rk[r] = rk_data;
        end
        ct = aes_enc(128'h00112233445566778899aabbccddeeff);
        n_vec++;
        if (ct !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
            n_err++; $display("FAIL cipher: got %h want 8ea2b7ca516745bfeafc49904b496089", ct);
        end
    endtask

    task automatic test_zero_key();
        exp_t e;
        int   cyc;
        tick();
        start_key(256'h0);
        wait_done(cyc);
        n_vec++; if (cyc != 52) begin n_err++; $display("FAIL zero_latency: got %0d want 52", cyc); end
        sb.push_back('{4'd0, 128'h0, "zero_rk0"});
        sb.push_back('{4'd1, 128'h0, "zero_rk1"});
        sb.push_back('{4'd2, 128'h62636363626363636263636362636363, "zero_rk2"});
        sb.push_back('{4'd3, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb, "zero_rk3"});
        ref_expand(256'h0);
        push_ref("zero");
        while (sb.size() > 0) begin
            e = sb.pop_front(); rk_addr = e.addr; @(negedge clk);
            n_vec++;
            if (rk_data !== e.data) begin n_err++; $display("FAIL %s: got %h want %h", e.tag, rk_data, e.data); end
        end
    endtask

    task automatic test_start_while_busy();
        exp_t e;
        int   cyc;
        tick();
        start_key(KEY1);
        for (int c = 0; c < 9; c++) tick();
        key_in = rand_key();
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(cyc);
        n_vec++; if (cyc < 0 || cyc + 10 != 52) begin
            n_err++; $display("FAIL busy_latency: got %0d want 52", (cyc < 0) ? cyc : cyc + 10); end
        sb.push_back('{4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "busy_rk14"});
        ref_expand(KEY1);
        push_ref("busy");
        while (sb.size() > 0) begin
            e = sb.pop_front(); rk_addr = e.addr; @(negedge clk);
            n_vec++;
            if (rk_data !== e.data) begin n_err++; $display("FAIL %s: got %h want %h", e.tag, rk_data, e.data); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t         e;
        int           cyc;
        int           seen_done;
        logic [255:0] k;
        tick();
        start_key(rand_key());
        for (int c = 0; c < 19; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL rstmid_flags: busy=%b rk_valid=%b done=%b want 0 0 0", busy, rk_valid, done); end
        seen_done = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (done !== 1'b0) seen_done++;
        end
        n_vec++; if (seen_done != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen_done); end
        k = rand_key();
        start_key(k);
        wait_done(cyc);
        n_vec++; if (cyc != 52) begin n_err++; $display("FAIL rstmid_latency: got %0d want 52", cyc); end
        ref_expand(k);
        push_ref("rstmid");
        while (sb.size() > 0) begin
            e = sb.pop_front(); rk_addr = e.addr; @(negedge clk);
            n_vec++;
            if (rk_data !== e.data) begin n_err++; $display("FAIL %s: got %h want %h", e.tag, rk_data, e.data); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        int           cyc;
        logic [255:0] k1, k2;
        k1 = rand_key();
        k2 = rand_key();
        tick();
        start_key(k1);
        wait_done(cyc);
        n_vec++; if (cyc != 52) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 52", cyc); end
        key_in = k2;
        start  = 1'b1;
        tick();
        n_vec++; if (busy !== 1'b0 || rk_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_start_on_done: busy=%b rk_valid=%b want 0 1", busy, rk_valid); end
        tick();
        start  = 1'b0;
        key_in = ~k2;
        n_vec++; if (busy !== 1'b1 || rk_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_accept: busy=%b rk_valid=%b want 1 0", busy, rk_valid); end
        wait_done(cyc);
        n_vec++; if (cyc != 52) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 52", cyc); end
        sb.push_back('{4'd15, 128'h0, "b2b_addr15"});
        ref_expand(k2);
        push_ref("b2b");
        while (sb.size() > 0) begin
            e = sb.pop_front(); rk_addr = e.addr; @(negedge clk);
            n_vec++;
            if (rk_data !== e.data) begin n_err++; $display("FAIL %s: got %h want %h", e.tag, rk_data, e.data); end
        end
    endtask

    initial begin
        test_reset();
        test_known_key();
        test_cipher();
        test_zero_key();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
